// File: rtl/grad_step_update.sv
// grad_step_update: collects gradient vectors, applies saturated fixed-point descent steps and writes coefficients back; GRAD_CLIP_EN enables gradient clamping.
module grad_step_update #(
  parameter int NUM_COEF = 10,
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS = 16,
  parameter logic signed [DATA_WIDTH-1:0] CLIP_MAX = 32'h0004_0000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [15:0]                  max_iter,
  input  logic signed [DATA_WIDTH-1:0] step,
  input  logic                         init_we,
  input  logic [3:0]                   init_addr,
  input  logic [DATA_WIDTH-1:0]        init_data,
  input  logic                         grad_valid,
  input  logic signed [DATA_WIDTH-1:0] grad_data,
  input  logic                         grad_last,
  input  logic                         objf_valid,
  input  logic [DATA_WIDTH-1:0]        objf_data,
  output logic                         coef_we,
  output logic [5:0]                   coef_addr,
  output logic [DATA_WIDTH-1:0]        coef_data,
  output logic                         op_objfunc,
  output logic                         busy,
  output logic                         done,
  output logic [15:0]                  iter_cnt,
  output logic [DATA_WIDTH-1:0]        f_last,
  output logic                         err_overrun
);
  localparam int DW = DATA_WIDTH;
  localparam int IW = $clog2(NUM_COEF + 1);
  localparam logic signed [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};
  typedef enum logic [2:0] {IDLE, WRITE, KICK, WAIT_GRAD, UPDATE, DONE} state_t;
  state_t state, state_nx;
  logic [IW-1:0] idx, k;
  logic signed [DW-1:0] coef [NUM_COEF];
  logic signed [DW-1:0] gbuf [NUM_COEF];
  logic signed [DW-1:0] step_r, g_in, new_coef;
  logic [15:0] max_iter_r;
  logic signed [2*DW-1:0] prod, delta;
  logic signed [2*DW:0] diff;
  logic last_idx;
  assign busy = state != IDLE;
  assign last_idx = idx == IW'(NUM_COEF - 1);
`ifdef GRAD_CLIP_EN
  assign g_in = grad_data > CLIP_MAX ? CLIP_MAX : grad_data < -CLIP_MAX ? -CLIP_MAX : grad_data;
`else
  assign g_in = grad_data;
`endif
  assign prod = step_r * gbuf[idx];
  assign delta = prod >>> FRAC_BITS;
  assign diff = (2*DW+1)'(coef[idx]) - (2*DW+1)'(delta);
  assign new_coef = diff > (2*DW+1)'(SMAX) ? SMAX : diff < (2*DW+1)'(SMIN) ? SMIN : diff[DW-1:0];
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      state_nx = start ? WRITE : IDLE;
      WRITE:     state_nx = last_idx ? (iter_cnt < max_iter_r ? KICK : DONE) : WRITE;
      KICK:      state_nx = WAIT_GRAD;
      WAIT_GRAD: state_nx = grad_valid && grad_last ? UPDATE : WAIT_GRAD;
      UPDATE:    state_nx = last_idx ? WRITE : UPDATE;
      default:   state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      k <= '0;
      for (int i = 0; i < NUM_COEF; i++) begin
        coef[i] <= '0;
        gbuf[i] <= '0;
      end
      step_r <= '0;
      max_iter_r <= '0;
      coef_we <= 1'b0;
      coef_addr <= '0;
      coef_data <= '0;
      op_objfunc <= 1'b0;
      done <= 1'b0;
      iter_cnt <= '0;
      f_last <= '0;
      err_overrun <= 1'b0;
    end else begin
      state <= state_nx;
      idx <= state == state_nx && (state == WRITE || state == UPDATE) ? idx + 1'b1 : '0;
      coef_we <= state == WRITE;
      coef_addr <= 6'(idx);
      coef_data <= coef[idx];
      op_objfunc <= state == KICK;
      done <= state == DONE;
      if (objf_valid) f_last <= objf_data;
      if (state == IDLE) begin
        if (init_we && 32'(init_addr) < NUM_COEF) coef[init_addr] <= init_data;
        if (start) begin
          step_r <= step;
          max_iter_r <= max_iter;
          iter_cnt <= '0;
        end
      end
      if (state == KICK) begin
        for (int i = 0; i < NUM_COEF; i++) gbuf[i] <= '0;
        k <= '0;
      end
      if (state == WAIT_GRAD && grad_valid) begin
        if (32'(k) < NUM_COEF) begin
          gbuf[k] <= g_in;
          k <= k + 1'b1;
        end else err_overrun <= 1'b1;
      end
      if (state == UPDATE) begin
        coef[idx] <= new_coef;
        if (last_idx) iter_cnt <= iter_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_grad_step_update.sv
// tb_grad_step_update: directed self-checking bench for grad_step_update.
module tb_grad_step_update;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, init_we = 1'b0;
  logic [15:0] max_iter = '0;
  logic signed [31:0] step = '0, grad_data = '0;
  logic [3:0] init_addr = '0;
  logic [31:0] init_data = '0, objf_data = '0;
  logic grad_valid = 1'b0, grad_last = 1'b0, objf_valid = 1'b0;
  logic coef_we, op_objfunc, busy, done, err_overrun;
  logic [5:0] coef_addr;
  logic [31:0] coef_data, f_last;
  logic [15:0] iter_cnt;
  logic [31:0] wr_mem [64];
  int we_cnt = 0, kick_cnt = 0, errors = 0, checks = 0;
  grad_step_update dut (
    .clk(clk), .rst(rst), .start(start), .max_iter(max_iter), .step(step),
    .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
    .grad_valid(grad_valid), .grad_data(grad_data), .grad_last(grad_last),
    .objf_valid(objf_valid), .objf_data(objf_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .op_objfunc(op_objfunc), .busy(busy), .done(done), .iter_cnt(iter_cnt),
    .f_last(f_last), .err_overrun(err_overrun)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (coef_we) begin
      wr_mem[coef_addr] = coef_data;
      we_cnt++;
    end
    if (op_objfunc) kick_cnt++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic init(input logic [3:0] a, input logic [31:0] d);
    init_we = 1'b1; init_addr = a; init_data = d;
    @(negedge clk);
    init_we = 1'b0;
  endtask
  task automatic go(input logic [15:0] mi, input logic [31:0] s);
    start = 1'b1; max_iter = mi; step = s;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic beat(input logic [31:0] d, input logic l);
    grad_valid = 1'b1; grad_data = d; grad_last = l;
    @(negedge clk);
    grad_valid = 1'b0; grad_last = 1'b0;
  endtask
  task automatic wait_kick(input string tag);
    int n = 0;
    while (!op_objfunc && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) check({tag, "_kick_timeout"}, 32'd0, 32'd1);
  endtask
  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) check({tag, "_done_timeout"}, 32'd0, 32'd1);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_coef_we", 32'(coef_we), 32'd0);
    check("rst_op", 32'(op_objfunc), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_iter", 32'(iter_cnt), 32'd0);
    check("rst_flast", f_last, 32'd0);
    check("rst_ovr", 32'(err_overrun), 32'd0);
    objf_valid = 1'b1; objf_data = 32'hCAFE_0001;
    @(negedge clk);
    objf_valid = 1'b0;
    check("flast_idle", f_last, 32'hCAFE_0001);
    init(4'd0, 32'h0001_0000);
    go(16'd1, 32'h0000_8000);
    check("busy_run", 32'(busy), 32'd1);
    wait_kick("basic");
    check("basic_wr0", wr_mem[0], 32'h0001_0000);
    check("basic_we10", 32'(we_cnt), 32'd10);
    beat(32'h0002_0000, 1'b1);
    wait_done("basic");
    check("basic_final0", wr_mem[0], 32'h0000_0000);
    check("basic_iter", 32'(iter_cnt), 32'd1);
    check("basic_we20", 32'(we_cnt), 32'd20);
    check("basic_kicks", 32'(kick_cnt), 32'd1);
    @(negedge clk);
    init(4'd0, 32'h7FFF_0000);
    go(16'd1, 32'h0001_0000);
    wait_kick("sat");
    beat(32'h8001_0000, 1'b1);
    wait_done("sat");
    check("sat_coef0", wr_mem[0], 32'h7FFF_FFFF);
    @(negedge clk);
    init(4'd0, 32'h0);
    go(16'd2, 32'h0001_0000);
    wait_kick("ovr");
    for (int i = 0; i < 12; i++) beat(-((i + 1) <<< 16), i == 11);
    wait_kick("ovr2");
    check("ovr_flag", 32'(err_overrun), 32'd1);
    for (int i = 0; i < 3; i++) beat(32'h0001_0000, i == 2);
    wait_done("ovr");
    check("ovr_iter", 32'(iter_cnt), 32'd2);
    check("ovr_sticky", 32'(err_overrun), 32'd1);
    for (int i = 0; i < 10; i++) check($sformatf("ovr_coef%0d", i), wr_mem[i], (i < 3 ? i : i + 1) << 16);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_clr_ovr", 32'(err_overrun), 32'd0);
    we_cnt = 0; kick_cnt = 0;
    start = 1'b1; max_iter = 16'd0; step = 32'h0001_0000;
    init_we = 1'b1; init_addr = 4'd5; init_data = 32'h0000_1234;
    @(negedge clk);
    start = 1'b0; init_we = 1'b0;
    wait_done("mi0");
    check("mi0_we", 32'(we_cnt), 32'd10);
    check("mi0_kicks", 32'(kick_cnt), 32'd0);
    check("mi0_coef5", wr_mem[5], 32'h0000_1234);
    check("mi0_iter", 32'(iter_cnt), 32'd0);
    @(negedge clk);
    go(16'd1, 32'h0001_0000);
    wait_kick("mrst");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_busy", 32'(busy), 32'd0);
    we_cnt = 0;
    repeat (20) @(negedge clk);
    check("mrst_no_we", 32'(we_cnt), 32'd0);
    check("mrst_busy_idle", 32'(busy), 32'd0);
`ifdef GRAD_CLIP_EN
    init(4'd0, 32'h0010_0000);
    go(16'd1, 32'h0001_0000);
    wait_kick("clip");
    beat(32'h0010_0000, 1'b1);
    wait_done("clip");
    check("clip_coef0", wr_mem[0], 32'h000C_0000);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
